// File: rtl/input_token_buffer_pkg.sv
// rtl/input_token_buffer_pkg.sv - keypad command codes and FSM state encoding for input_token_buffer
// Purpose: shared keypad command codes (IC_*) and the token buffer state encoding.
// Ports: none (package).
package input_token_buffer_pkg;

    // Keypad command codes
    localparam int IC_N = 5;
    localparam logic [IC_N-1:0] IC_NONE = 5'd0;
    localparam logic [IC_N-1:0] IC_NUM0 = 5'd1;   // NUM0..NUM9 are 1..10
    localparam logic [IC_N-1:0] IC_NUM9 = 5'd10;
    localparam logic [IC_N-1:0] IC_NUMA = 5'd11;  // NUMA..NUMF are 11..16
    localparam logic [IC_N-1:0] IC_NUMF = 5'd16;
    localparam logic [IC_N-1:0] IC_OPAD = 5'd17;
    localparam logic [IC_N-1:0] IC_OPSB = 5'd18;
    localparam logic [IC_N-1:0] IC_CTOK = 5'd19;
    localparam logic [IC_N-1:0] IC_BKSP = 5'd20;
    localparam logic [IC_N-1:0] IC_CLR  = 5'd21;

    // Internal state encoding
    typedef enum logic [1:0] {
        S_SRC = 2'd0,
        S_DST = 2'd1,
        S_OUT = 2'd2
    } state_t;

endpackage

// File: rtl/input_digit_acc.sv
// rtl/input_digit_acc.sv - combinational multiply-add of one digit into the operand accumulator
// Purpose: next = acc*radix + d evaluated at DW+5 bits, flagging results that do not fit in DW bits.
// Ports: acc (current value), d (digit 0..15), radix (10 or 16),
//        next (low DW bits of the sum), ovf (sum does not fit in DW bits).
module input_digit_acc #(
    parameter int DW = 16
) (
    input  logic [DW-1:0] acc,
    input  logic [3:0]    d,
    input  logic [4:0]    radix,
    output logic [DW-1:0] next,
    output logic          ovf
);

    // Five guard bits cover the worst case (2^DW-1)*16+15.
    logic [DW+4:0] wide;

    assign wide = ({5'd0, acc} * {{DW{1'b0}}, radix}) + {{(DW+1){1'b0}}, d};
    assign next = wide[DW-1:0];
    assign ovf  = |wide[DW+4:DW];

endmodule

// File: rtl/input_token_buffer.sv
// rtl/input_token_buffer.sv - keypad token buffer assembling SRC/operator/DST results
// Purpose: accumulates keypad digits into two operands and an operator, presenting a
//          result with a valid/ready handshake.
// Ports: Clock, Reset (sync active-low), mode (0 dec / 1 hex), cmd_valid/cmd/cmd_ready
//        (command input), SRC/DST/ALU_OP/out_valid/out_ready (result output),
//        overflow (sticky rejected-digit flag).
module input_token_buffer
    import input_token_buffer_pkg::*;
#(
    parameter int DW     = 16,
    parameter bit HEX_EN = 1'b1
) (
    input  logic            Clock,
    input  logic            Reset,
    input  logic            mode,
    input  logic            cmd_valid,
    input  logic [IC_N-1:0] cmd,
    output logic            cmd_ready,
    output logic [DW-1:0]   SRC,
    output logic [DW-1:0]   DST,
    output logic [IC_N-1:0] ALU_OP,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            overflow
);

    state_t        state;
    logic [DW-1:0] acc;
    logic          hex;
    logic [4:0]    radix;
    logic          is_digit;
    logic [3:0]    digit;
    logic [DW-1:0] acc_next;
    logic          acc_ovf;
    logic [DW-1:0] acc_div;
    logic          accept;

    assign cmd_ready = (state != S_OUT);
    assign accept    = cmd_valid && cmd_ready;
    assign hex       = HEX_EN && mode;
    assign radix     = hex ? 5'd16 : 5'd10;
    assign acc_div   = hex ? (acc >> 4) : (acc / DW'(10));

    // Hex letters only count as digits in hex mode; otherwise they fall through as no-ops.
    always_comb begin
        is_digit = 1'b0;
        digit    = 4'd0;
        if (cmd >= IC_NUM0 && cmd <= IC_NUM9) begin
            is_digit = 1'b1;
            digit    = 4'(cmd - IC_NUM0);
        end else if (cmd >= IC_NUMA && cmd <= IC_NUMF && hex) begin
            is_digit = 1'b1;
            digit    = 4'(cmd - IC_NUM0);
        end
    end

    input_digit_acc #(.DW(DW)) u_digit_acc (
        .acc   (acc),
        .d     (digit),
        .radix (radix),
        .next  (acc_next),
        .ovf   (acc_ovf)
    );

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state     <= S_SRC;
            acc       <= '0;
            SRC       <= '0;
            DST       <= '0;
            ALU_OP    <= IC_NONE;
            out_valid <= 1'b0;
            overflow  <= 1'b0;
        end else if (state == S_OUT) begin
            if (out_ready) begin
                out_valid <= 1'b0;
                state     <= S_SRC;
            end
        end else if (accept) begin
            if (is_digit) begin
                if (acc_ovf) begin
                    overflow <= 1'b1;
                end else begin
                    acc <= acc_next;
                end
            end else begin
                case (cmd)
                    IC_BKSP: acc <= acc_div;
                    IC_OPAD, IC_OPSB: begin
                        // A second operator while entering DST only corrects the operator.
                        ALU_OP <= cmd;
                        if (state == S_SRC) begin
                            SRC   <= acc;
                            acc   <= '0;
                            state <= S_DST;
                        end
                    end
                    IC_CTOK: begin
                        if (state == S_DST) begin
                            DST <= acc;
                        end else begin
                            SRC    <= acc;
                            DST    <= '0;
                            ALU_OP <= IC_NONE;
                        end
                        acc       <= '0;
                        out_valid <= 1'b1;
                        state     <= S_OUT;
                    end
                    IC_CLR: begin
                        acc      <= '0;
                        overflow <= 1'b0;
                        state    <= S_SRC;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_input_token_buffer.sv
// tb/tb_input_token_buffer.sv - self-checking bench for input_token_buffer
module tb_input_token_buffer;
    import input_token_buffer_pkg::*;

    localparam int DW = 16;

    logic            Clock;
    logic            Reset;
    logic            mode;
    logic            cmd_valid;
    logic [IC_N-1:0] cmd;
    logic            cmd_ready;
    logic [DW-1:0]   SRC;
    logic [DW-1:0]   DST;
    logic [IC_N-1:0] ALU_OP;
    logic            out_valid;
    logic            out_ready;
    logic            overflow;

    int compared;
    int mismatched;

    // Reference model: operands as plain integers, a pending flag, and a flag for
    // whether an operator has been entered.
    longint    m_acc, m_src, m_dst;
    logic [4:0] m_op;
    bit        m_pend, m_second, m_ovf;

    bit cur_mode;
    bit cur_ordy;

    input_token_buffer #(.DW(DW), .HEX_EN(1'b1)) dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .mode      (mode),
        .cmd_valid (cmd_valid),
        .cmd       (cmd),
        .cmd_ready (cmd_ready),
        .SRC       (SRC),
        .DST       (DST),
        .ALU_OP    (ALU_OP),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .overflow  (overflow)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model(input bit r, input bit v, input logic [4:0] c, input bit m, input bit o);
        longint radix;
        longint d;
        longint nx;
        if (!r) begin
            m_acc = 0; m_src = 0; m_dst = 0; m_op = IC_NONE;
            m_pend = 0; m_second = 0; m_ovf = 0;
        end else if (m_pend) begin
            if (o) m_pend = 0;
        end else if (v) begin
            radix = m ? 16 : 10;
            if (c >= 5'd1 && c <= 5'd16) begin
                d = longint'(c) - 1;
                if (!(d >= 10 && radix == 10)) begin
                    nx = m_acc * radix + d;
                    if (nx < (64'd1 << DW)) m_acc = nx;
                    else m_ovf = 1;
                end
            end else if (c == IC_BKSP) begin
                m_acc = m_acc / radix;
            end else if (c == IC_OPAD || c == IC_OPSB) begin
                if (!m_second) begin
                    m_src = m_acc; m_acc = 0; m_second = 1;
                end
                m_op = c;
            end else if (c == IC_CTOK) begin
                if (m_second) m_dst = m_acc;
                else begin m_src = m_acc; m_dst = 0; m_op = IC_NONE; end
                m_acc = 0; m_pend = 1; m_second = 0;
            end else if (c == IC_CLR) begin
                m_acc = 0; m_ovf = 0; m_second = 0;
            end
        end
    endtask

    task automatic step(input bit r, input bit v, input logic [4:0] c, input bit m, input bit o);
        Reset = r; cmd_valid = v; cmd = c; mode = m; out_ready = o;
        model(r, v, c, m, o);
        @(posedge Clock);
        #1;
        chk("cmd_ready", 64'(cmd_ready), 64'(!m_pend));
        chk("out_valid", 64'(out_valid), 64'(m_pend));
        chk("SRC", 64'(SRC), 64'(m_src));
        chk("DST", 64'(DST), 64'(m_dst));
        chk("ALU_OP", 64'(ALU_OP), 64'(m_op));
        chk("overflow", 64'(overflow), 64'(m_ovf));
    endtask

    task automatic key(input logic [4:0] c);
        step(1'b1, 1'b1, c, cur_mode, cur_ordy);
    endtask

    task automatic idle();
        step(1'b1, 1'b0, IC_NONE, cur_mode, cur_ordy);
    endtask

    function automatic logic [4:0] nk(input int d);
        return 5'(int'(IC_NUM0) + d);
    endfunction

    initial begin
        compared = 0; mismatched = 0;
        cur_mode = 0; cur_ordy = 0;
        Reset = 0; mode = 0; cmd_valid = 0; cmd = IC_NONE; out_ready = 0;

        // Reset state
        step(1'b0, 1'b0, IC_NONE, 1'b0, 1'b0);
        step(1'b0, 1'b1, nk(3), 1'b0, 1'b1);
        chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_SRC", 64'(SRC), 64'd0);
        chk("rst_ALU_OP", 64'(ALU_OP), 64'(IC_NONE));

        // Decimal add
        cur_ordy = 1;
        key(nk(5)); key(nk(6)); key(IC_OPAD); key(nk(3)); key(nk(7)); key(IC_CTOK);
        chk("add_out_valid", 64'(out_valid), 64'd1);
        chk("add_SRC", 64'(SRC), 64'd56);
        chk("add_DST", 64'(DST), 64'd37);
        chk("add_ALU_OP", 64'(ALU_OP), 64'(IC_OPAD));
        idle();
        chk("add_out_valid_1cyc", 64'(out_valid), 64'd0);

        // Backpressure
        cur_ordy = 0;
        key(nk(4)); key(nk(9)); key(IC_OPSB); key(nk(4)); key(IC_CTOK);
        for (int i = 0; i < 5; i++) begin
            key(nk(1));
            chk("bp_cmd_ready", 64'(cmd_ready), 64'd0);
            chk("bp_SRC", 64'(SRC), 64'd49);
            chk("bp_DST", 64'(DST), 64'd4);
        end
        cur_ordy = 1;
        key(nk(1));
        chk("bp_release_valid", 64'(out_valid), 64'd0);
        cur_ordy = 0;
        key(nk(1));
        key(IC_CTOK);
        chk("bp_one_digit_SRC", 64'(SRC), 64'd1);
        cur_ordy = 1;
        idle();

        // Overflow
        key(IC_CLR);
        key(nk(6)); key(nk(5)); key(nk(5)); key(nk(3)); key(nk(5));
        chk("ovf_before", 64'(overflow), 64'd0);
        key(nk(9));
        chk("ovf_set", 64'(overflow), 64'd1);
        key(IC_CTOK);
        chk("ovf_SRC", 64'(SRC), 64'd65535);
        idle();
        chk("ovf_sticky", 64'(overflow), 64'd1);
        key(IC_CLR);
        chk("ovf_clr", 64'(overflow), 64'd0);

        // Hex mode and backspace
        cur_mode = 1;
        key(5'(IC_NUMA)); key(IC_NUMF); key(nk(1)); key(IC_BKSP); key(IC_OPAD); key(IC_CTOK);
        chk("hex_SRC", 64'(SRC), 64'h00AF);
        chk("hex_DST", 64'(DST), 64'd0);
        idle();
        cur_mode = 0;
        key(IC_NUMA); key(nk(3)); key(IC_CTOK);
        chk("dec_ignores_A", 64'(SRC), 64'd3);
        idle();
        key(IC_BKSP); key(IC_CTOK);
        chk("bksp_zero", 64'(SRC), 64'd0);
        idle();

        // Operator correction and lone CTOK
        key(nk(9)); key(IC_OPAD); key(IC_OPSB); key(nk(2)); key(IC_CTOK);
        chk("opfix_ALU_OP", 64'(ALU_OP), 64'(IC_OPSB));
        chk("opfix_SRC", 64'(SRC), 64'd9);
        chk("opfix_DST", 64'(DST), 64'd2);
        idle();
        key(nk(7)); key(IC_CTOK);
        chk("lone_SRC", 64'(SRC), 64'd7);
        chk("lone_ALU_OP", 64'(ALU_OP), 64'(IC_NONE));
        idle();

        // Reset while a result is pending
        cur_ordy = 0;
        key(nk(8)); key(IC_OPAD); key(nk(1)); key(IC_CTOK);
        chk("pre_rst_valid", 64'(out_valid), 64'd1);
        step(1'b0, 1'b1, nk(2), 1'b0, 1'b1);
        chk("rst_pend_valid", 64'(out_valid), 64'd0);
        chk("rst_pend_SRC", 64'(SRC), 64'd0);
        chk("rst_pend_DST", 64'(DST), 64'd0);
        chk("rst_pend_ready", 64'(cmd_ready), 64'd1);

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            bit r, v, m, o;
            int x;
            logic [4:0] c;
            r = ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
            v = ($urandom_range(0, 4) != 0);
            m = 1'($urandom_range(0, 1));
            o = 1'($urandom_range(0, 1));
            x = $urandom_range(0, 99);
            if (x < 55)      c = nk($urandom_range(0, 15));
            else if (x < 65) c = ($urandom_range(0, 1) != 0) ? IC_OPAD : IC_OPSB;
            else if (x < 75) c = IC_CTOK;
            else if (x < 83) c = IC_BKSP;
            else if (x < 88) c = IC_CLR;
            else if (x < 94) c = IC_NONE;
            else             c = 5'($urandom_range(22, 31));
            step(r, v, c, m, o);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/input_token_buffer.md
INPUT_TOKEN_BUFFER -- requirements
Module: input_token_buffer

Interface
REQ-001 Parameter DW, default 16: operand width in bits, legal range 4..32.
REQ-002 Parameter HEX_EN, default 1: 1 means hex digits are accepted when mode=1; 0 means mode is ignored and decimal is forced.
REQ-003 Port Clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 Port Reset, input, 1 bit: synchronous, active-low reset.
REQ-005 Port mode, input, 1 bit: radix select, 0 = decimal, 1 = hex; sampled with each accepted digit.
REQ-006 Port cmd_valid, input, 1 bit: cmd holds a command.
REQ-007 Port cmd, input, IC_N bits: keypad command code (IC_* encoding).
REQ-008 Port cmd_ready, output, 1 bit: a command is accepted when cmd_valid & cmd_ready.
REQ-009 Port SRC, output, DW bits: first operand of the pending result.
REQ-010 Port DST, output, DW bits: second operand of the pending result.
REQ-011 Port ALU_OP, output, IC_N bits: operator code of the pending result.
REQ-012 Port out_valid, output, 1 bit: result pending.
REQ-013 Port out_ready, input, 1 bit: consumer takes the result when out_valid & out_ready.
REQ-014 Port overflow, output, 1 bit: sticky flag; set when a digit was rejected.

Function
REQ-015 FSM states: S_SRC (entering SRC), S_DST (entering DST), S_OUT (result pending).
- S_SRC and S_DST work on an internal DW-bit accumulator acc.
REQ-016 cmd_ready = (state != S_OUT), driven directly from the state register.
REQ-017 Every accepted command takes effect at the accepting edge; when cmd_valid is low, no state changes.
REQ-018 Digit d (IC_NUM0..9; IC_NUMA..F only when HEX_EN=1 and mode=1), radix R = 10 or 16:
- next = acc*R + d, computed at DW+5 bits.
- next < 2^DW: acc <= next.
- otherwise: acc unchanged and overflow <= 1.
REQ-019 Digits IC_NUMA..F received in decimal mode are ignored.
REQ-020 IC_BKSP: acc <= acc / R (truncating); BKSP with acc=0 leaves acc=0.
REQ-021 Operator (IC_OPAD, IC_OPSB) in S_SRC: SRC <= acc; ALU_OP <= cmd; acc <= 0; go to S_DST.
REQ-022 Operator in S_DST: ALU_OP <= cmd (operator correction); acc kept; stay in S_DST.
REQ-023 IC_CTOK in S_DST: DST <= acc; acc <= 0; out_valid <= 1; go to S_OUT.
REQ-024 IC_CTOK in S_SRC: SRC <= acc; DST <= 0; ALU_OP <= IC_NONE; acc <= 0; out_valid <= 1; go to S_OUT.
REQ-025 IC_CLR in any state other than S_OUT: acc <= 0; overflow <= 0; go to S_SRC; SRC, DST and ALU_OP unchanged.
REQ-026 IC_NONE and any unlisted code: no effect.
REQ-027 In S_OUT, SRC, DST and ALU_OP are held stable.
- On out_ready: out_valid <= 0 and go to S_SRC.
- cmd_ready reasserts in the following cycle, so the earliest next command is 1 cycle after the handshake.
REQ-028 out_ready is ignored while out_valid=0.
REQ-029 overflow is cleared only by IC_CLR or reset; it is unaffected by result delivery.

Reset
REQ-030 When Reset=0 at a rising edge of Clock:
- state <= S_SRC; acc <= 0; SRC <= 0; DST <= 0; ALU_OP <= IC_NONE; out_valid <= 0; overflow <= 0.
- cmd_ready=1 from the following cycle.
REQ-031 Reset while in S_OUT discards the pending result without any handshake.
- Reset has priority over any simultaneous command or out_ready.

Structure
REQ-032 The IC_* command codes and IC_N belong in the shared INPUT_INTERFACE include; IC_BKSP and IC_CLR are added there.
REQ-033 The state encodings belong in INPUT_INTERNAL.
REQ-034 The multiply-add and overflow check go in a combinational sub-module, input_digit_acc.
- Parameter: DW.
- Inputs: acc, d, radix.
- Outputs: next, ovf.

Verification
REQ-035 Decimal add: 5,6,OPAD,3,7,CTOK with out_ready=1 -> out_valid for 1 cycle with SRC=56, DST=37, ALU_OP=IC_OPAD.
REQ-036 Backpressure:
- Stimulus: 4,9,OPSB,4,CTOK with out_ready=0 for 5 cycles while a NUM1 is offered.
- Required: cmd_ready=0 and SRC=49, DST=4 held; NUM1 not accepted until 1 cycle after out_ready=1.
REQ-037 Overflow at DW=16: 6,5,5,3,5,9 -> acc=65535 after the fifth digit; the last digit is rejected and overflow=1.
- Then CTOK gives SRC=65535; CLR clears overflow.
REQ-038 Hex mode and backspace:
- mode=1: A,F,1,BKSP,OPAD,CTOK -> SRC=0x00AF, DST=0.
- mode=0: A is ignored.
REQ-039 Operator correction and lone CTOK:
- 9,OPAD,OPSB,2,CTOK -> ALU_OP=IC_OPSB.
- 7,CTOK -> SRC=7, ALU_OP=IC_NONE.
REQ-040 Reset pulse while out_valid=1 -> next cycle out_valid=0, SRC=DST=0, cmd_ready=1.
